gpio_cfg_loader: RTL and testbench
==================================

// Module: gpio_cfg_loader
// PURPOSE
// - Master side of the GPIO pad serial configuration chain.
// - Holds a per-pad shadow config, shifts it serially through NUM_PADS chained pad control blocks,
//   then pulses serial_load; optional verify pass re-shifts and checks the chain loopback.
// - Sits between the SoC register bank and the first pad control block; chain end returns on serial_data_in.
// PARAMETERS
// - NUM_PADS       6       pads in the chain (>=1)
// - PAD_CTRL_BITS  12      config bits per pad
// - CLK_DIV        2       mclk cycles per serial_clock half-period (>=1)
// - DEFAULT_CFG    12'hC00 shadow reset value, every pad
// PORTS
// - mclk             in   1                  core clock
// - resetn           in   1                  reset, synchronous, active-low
// - cfg_wr           in   1                  write shadow[cfg_idx] <= cfg_wdata
// - cfg_idx          in   $clog2(NUM_PADS)   pad index for write/read
// - cfg_wdata        in   PAD_CTRL_BITS      write data
// - cfg_rdata        out  PAD_CTRL_BITS      shadow[cfg_idx], combinational; 0 if idx>=NUM_PADS
// - start            in   1                  begin load sequence (accepted only when !busy)
// - verify           in   1                  sampled with start: run verify pass
// - busy             out  1                  sequence in progress
// - done             out  1                  1-cycle pulse at sequence end
// - loopback_err     out  1                  sticky verify mismatch, cleared by accepted start
// - serial_clock     out  1                  chain shift clock
// - serial_load      out  1                  chain load strobe
// - serial_data_out  out  1                  chain data toward pad 0
// - serial_data_in   in   1                  chain return from pad NUM_PADS-1
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, every shadow entry = DEFAULT_CFG.
// - Reset asserted mid-sequence aborts at the next edge; no done and no load pulse are issued.
// - TOTAL = NUM_PADS*PAD_CTRL_BITS. Bit order: pad NUM_PADS-1 MSB first ... pad 0 LSB last.
// - Writes are accepted only in IDLE. Writes while busy or with cfg_idx>=NUM_PADS are dropped silently.
// - cfg_wr and start in the same IDLE cycle: the write lands and is included in the shifted data.
// - start while busy is ignored. verify is latched only on an accepted start.
// - FSM states:
//   - IDLE
//   - SHIFT_LO: clk=0, data updated on entry
//   - SHIFT_HI: clk=1
//   - LOAD: load=1 for CLK_DIV, then 0 for CLK_DIV
//   - DONE: done=1 for 1 cycle, then IDLE
// - Transitions:
//   - IDLE->SHIFT_LO on start.
//   - Each state lasts CLK_DIV cycles.
//   - SHIFT_HI->SHIFT_LO while bits remain.
//   - After bit TOTAL: LOAD (pass 0) or DONE (pass 1).
//   - LOAD->SHIFT_LO for pass 1 if verify, else ->DONE.
// - Serial data is stable for the whole of SHIFT_LO and SHIFT_HI of its bit.
// - serial_clock and serial_load are never high together.
// - busy=1 from the cycle after an accepted start through the DONE cycle inclusive.
// - Cycle counts: non-verify = 2*CLK_DIV*(TOTAL+1) busy cycles before DONE; verify adds 2*CLK_DIV*TOTAL.
// - Verify pass:
//   - Resend the identical sequence with no second load.
//   - In the last mclk of each SHIFT_LO, compare serial_data_in against the bit being sent.
//   - Any mismatch sets loopback_err; it stays set until the next accepted start.
// - Bit counter: $clog2(TOTAL+1) bits. Divider counter: $clog2(CLK_DIV) bits, minimum 1; no wrap past TOTAL.
// STRUCTURE
// - Package gpio_cfg_pkg: state enum (IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE) and function cfg_bit_sel(idx) mapping
//   sequence index to {pad, bit}.
// - Sub-module gpio_cfg_shadow: NUM_PADS x PAD_CTRL_BITS register file.
//   - Write port, read port, and a serial bit-select read port.
//   - Reset to DEFAULT_CFG.
// - Top holds the FSM, divider, bit counter, pass flag and comparator.
// TESTING
// - Params 6/12/2, no writes, start, verify=0:
//   - 72 bits out, pattern = (12'hC00 x6) MSB-first.
//   - One load pulse of 2 cycles.
//   - done exactly 292 cycles after busy rises.
// - Write pad5=12'hABC, pad0=12'h001; start verify=1 with an ideal chain model (shift regs + load):
//   - Model regs end 12'hABC/12'h001.
//   - loopback_err=0; busy cycles = 580.
// - Same test with a chain model whose bit 17 is stuck at 1 and the driven value 0:
//   - loopback_err=1 after done; it clears on the next start.
// - Pulse start and cfg_wr (pad2=12'h555) mid-shift:
//   - Both ignored: waveform unchanged, cfg_rdata(2) still 12'hC00.
//   - Same-cycle cfg_wr+start in IDLE: 12'h555 appears in the stream.
// - Deassert resetn at bit 30:
//   - Next cycle all outputs 0, no done.
//   - Shadow reads 12'hC00; a fresh start runs a full sequence.
// - cfg_idx=7 write of 12'hFFF: no shadow changes, cfg_rdata=0.

Source files
------------

// File: rtl/gpio_cfg_pkg.sv
// Shared types for the GPIO pad configuration chain loader.
// Sequence index 0 is pad NUM_PADS-1 MSB; the last index is pad 0 LSB.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  typedef struct packed {
    logic [15:0] pad;
    logic [15:0] bitn;
  } bsel_t;

  function automatic bsel_t cfg_bit_sel(
    input int idx,
    input int np,
    input int pb
  );
    bsel_t s;
    s.pad  = 16'(np - 1 - idx / pb);
    s.bitn = 16'(pb - 1 - idx % pb);
    return s;
  endfunction

endpackage

// File: rtl/gpio_cfg_shadow.sv
// Per-pad shadow configuration register file.
// Provides a write port, a word read port and a serial bit-select port.
module gpio_cfg_shadow
  import gpio_cfg_pkg::*;
#(
  parameter int NP = 6,
  parameter int PB = 12,
  parameter int IW = 3,
  parameter int CW = 7,
  parameter logic [PB-1:0] DEF = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [PB-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [PB-1:0] rd_data,
  input  logic [CW-1:0] sel_idx,
  output logic          sel_bit
);

  logic [PB-1:0] mem [NP];
  bsel_t sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) mem[p] <= DEF;
    end else if (wr_en) begin
      for (int p = 0; p < NP; p++)
        if (wr_idx == IW'(p)) mem[p] <= wr_data;
    end
  end

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NP; p++)
      if (rd_idx == IW'(p)) rd_data = mem[p];
  end

  always_comb begin
    sel = cfg_bit_sel(int'(sel_idx), NP, PB);
    sel_bit = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int b = 0; b < PB; b++)
        if (sel.pad == 16'(p) && sel.bitn == 16'(b))
          sel_bit = mem[p][b];
  end

endmodule

// File: rtl/gpio_cfg_loader.sv
// GPIO pad serial configuration chain master.
// Shifts the shadow config out, strobes load, optionally verifies loopback.
module gpio_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 6,
  parameter int PAD_CTRL_BITS = 12,
  parameter int CLK_DIV = 2,
  parameter logic [PAD_CTRL_BITS-1:0] DEFAULT_CFG = 12'hC00,
  localparam int IW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                     mclk,
  input  logic                     resetn,
  input  logic                     cfg_wr,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
  output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
  input  logic                     start,
  input  logic                     verify,
  output logic                     busy,
  output logic                     done,
  output logic                     loopback_err,
  output logic                     serial_clock,
  output logic                     serial_load,
  output logic                     serial_data_out,
  input  logic                     serial_data_in
);

  localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, bit_nx;
  logic [DW-1:0] div_cnt;
  logic ld_ph, ld_ph_nx;
  logic pass, pass_nx;
  logic vfy, err;
  logic div_end, accept, sel_bit, shifting;

  assign div_end  = (div_cnt == DMAX);
  assign accept   = start && (state == IDLE);
  assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);

  gpio_cfg_shadow #(
    .NP  (NUM_PADS),
    .PB  (PAD_CTRL_BITS),
    .IW  (IW),
    .CW  (CW),
    .DEF (DEFAULT_CFG)
  ) u_shadow (
    .clk     (mclk),
    .rst_n   (resetn),
    .wr_en   (cfg_wr && (state == IDLE)),
    .wr_idx  (cfg_idx),
    .wr_data (cfg_wdata),
    .rd_idx  (cfg_idx),
    .rd_data (cfg_rdata),
    .sel_idx (bit_cnt),
    .sel_bit (sel_bit)
  );

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    ld_ph_nx = ld_ph;
    pass_nx  = pass;
    unique case (state)
      IDLE: if (start) begin
        state_nx = SHIFT_LO;
        bit_nx   = '0;
        pass_nx  = 1'b0;
      end
      SHIFT_LO: if (div_end) state_nx = SHIFT_HI;
      SHIFT_HI: if (div_end) begin
        if (bit_cnt == LAST) begin
          bit_nx   = '0;
          state_nx = pass ? DONE : LOAD;
        end else begin
          bit_nx   = bit_cnt + 1'b1;
          state_nx = SHIFT_LO;
        end
      end
      // Two divider periods: strobe high, then a quiet gap.
      LOAD: if (div_end) begin
        ld_ph_nx = ~ld_ph;
        if (ld_ph) begin
          state_nx = vfy ? SHIFT_LO : DONE;
          pass_nx  = 1'b1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      ld_ph   <= 1'b0;
      pass    <= 1'b0;
      vfy     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      ld_ph   <= ld_ph_nx;
      pass    <= pass_nx;
      if (div_end || state == IDLE || state == DONE)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
      if (accept) begin
        vfy <= verify;
        err <= 1'b0;
      end else if (state == SHIFT_LO && div_end && pass &&
                   serial_data_in != sel_bit) begin
        err <= 1'b1;
      end
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign serial_clock    = (state == SHIFT_HI);
  assign serial_load     = (state == LOAD) && !ld_ph;
  assign serial_data_out = shifting && sel_bit;
  assign loopback_err    = err;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Self-checking bench for gpio_cfg_loader with a serial chain model.
// Stream bits are scoreboarded against a bench-side shadow model.
module tb_gpio_cfg_loader;

  localparam int NP = 6;
  localparam int PB = 12;
  localparam int CD = 2;
  localparam int TOTAL = NP * PB;

  logic mclk = 1'b0;
  logic resetn = 1'b0;
  logic cfg_wr = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [11:0] cfg_wdata = '0;
  logic [11:0] cfg_rdata;
  logic start = 1'b0;
  logic verify = 1'b0;
  logic busy, done, loopback_err;
  logic serial_clock, serial_load, serial_data_out;
  logic serial_data_in;

  int total = 0;
  int bad = 0;
  int ovl = 0;
  logic q_exp[$];
  logic [11:0] shm [NP];
  logic [11:0] pad_reg [NP];
  logic [TOTAL-1:0] sr = '0;
  logic [TOTAL-1:0] sr_n;
  logic stuck = 1'b0;
  logic mon_en = 1'b0;
  logic exp_b;

  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [11:0] wd;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[10];

  always #5 mclk = ~mclk;

  gpio_cfg_loader dut (
    .mclk            (mclk),
    .resetn          (resetn),
    .cfg_wr          (cfg_wr),
    .cfg_idx         (cfg_idx),
    .cfg_wdata       (cfg_wdata),
    .cfg_rdata       (cfg_rdata),
    .start           (start),
    .verify          (verify),
    .busy            (busy),
    .done            (done),
    .loopback_err    (loopback_err),
    .serial_clock    (serial_clock),
    .serial_load     (serial_load),
    .serial_data_out (serial_data_out),
    .serial_data_in  (serial_data_in)
  );

  assign serial_data_in = sr[TOTAL-1];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Chain model: shift on serial_clock rise, capture pads on load.
  always @(posedge serial_clock) begin
    sr_n = {sr[TOTAL-2:0], serial_data_out};
    if (stuck) sr_n[17] = 1'b1;
    sr <= sr_n;
    if (mon_en) begin
      if (q_exp.size() == 0) begin
        check("extra_bit", 1, 0);
      end else begin
        exp_b = q_exp.pop_front();
        check("stream_bit", 32'(serial_data_out), 32'(exp_b));
      end
    end
  end

  always @(posedge serial_load)
    for (int p = 0; p < NP; p++) pad_reg[p] = sr[p*PB +: PB];

  always @(negedge mclk)
    if (serial_clock && serial_load) ovl++;

  task automatic push_seq();
    logic [TOTAL-1:0] flat;
    for (int p = 0; p < NP; p++) flat[p*PB +: PB] = shm[p];
    for (int i = TOTAL - 1; i >= 0; i--) q_exp.push_back(flat[i]);
  endtask

  task automatic reset_model();
    for (int p = 0; p < NP; p++) shm[p] = 12'hC00;
  endtask

  task automatic run_seq(
    input logic vf,
    input int poke_at,
    input int abort_at,
    input logic wr_now,
    input logic [2:0] widx,
    input logic [11:0] wdat,
    input int exp_cyc,
    input string nm
  );
    int cnt = 0;
    int lcyc = 0;
    int lrise = 0;
    int k = 0;
    logic lprev = 1'b0;
    logic got_done = 1'b0;
    logic aborted = 1'b0;
    @(negedge mclk);
    start = 1'b1;
    verify = vf;
    if (wr_now) begin
      cfg_wr = 1'b1;
      cfg_idx = widx;
      cfg_wdata = wdat;
      if (int'(widx) < NP) shm[widx] = wdat;
    end
    q_exp.delete();
    push_seq();
    if (vf) push_seq();
    mon_en = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    cfg_wr = 1'b0;
    verify = 1'b0;
    check({nm, "_err_clr"}, 32'(loopback_err), 0);
    while (!got_done && !aborted && k < 2000) begin
      k++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) cnt++;
        if (serial_load) lcyc++;
        if (serial_load && !lprev) lrise++;
        lprev = serial_load;
        if (cnt == poke_at) begin
          start = 1'b1;
          cfg_wr = 1'b1;
          cfg_idx = 3'd2;
          cfg_wdata = 12'h555;
        end
        if (cnt == abort_at) begin
          resetn = 1'b0;
          aborted = 1'b1;
        end
        @(negedge mclk);
        start = 1'b0;
        cfg_wr = 1'b0;
      end
    end
    if (aborted) begin
      check({nm, "_abort_outs"},
            32'({busy, done, loopback_err, serial_clock,
                 serial_load, serial_data_out}), 0);
      mon_en = 1'b0;
      q_exp.delete();
      @(negedge mclk);
      check({nm, "_abort_nodone"}, 32'(done), 0);
      resetn = 1'b1;
      reset_model();
      return;
    end
    mon_en = 1'b0;
    check({nm, "_done_seen"}, 32'(got_done), 1);
    check({nm, "_busy_cyc"}, cnt, exp_cyc);
    check({nm, "_bits_left"}, q_exp.size(), 0);
    check({nm, "_load_pulses"}, lrise, 1);
    check({nm, "_load_cyc"}, lcyc, CD);
    @(negedge mclk);
    check({nm, "_idle_after"}, 32'({busy, done}), 0);
  endtask

  initial begin
    reset_model();
    tbl[0] = '{1'b0, 3'd0, 12'h000, 12'hC00};
    tbl[1] = '{1'b0, 3'd5, 12'h000, 12'hC00};
    tbl[2] = '{1'b1, 3'd7, 12'hFFF, 12'h000};
    tbl[3] = '{1'b0, 3'd0, 12'h000, 12'hC00};
    tbl[4] = '{1'b0, 3'd3, 12'h000, 12'hC00};
    tbl[5] = '{1'b1, 3'd5, 12'hABC, 12'hABC};
    tbl[6] = '{1'b1, 3'd0, 12'h001, 12'h001};
    tbl[7] = '{1'b0, 3'd5, 12'h000, 12'hABC};
    tbl[8] = '{1'b0, 3'd1, 12'h000, 12'hC00};
    tbl[9] = '{1'b0, 3'd7, 12'h000, 12'h000};

    repeat (3) @(negedge mclk);
    check("reset_outs",
          32'({busy, done, loopback_err, serial_clock,
               serial_load, serial_data_out}), 0);
    resetn = 1'b1;

    run_seq(1'b0, -1, -1, 1'b0, 3'd0, 12'h0, 292, "t1");

    for (int i = 0; i < 10; i++) begin
      @(negedge mclk);
      cfg_wr = tbl[i].wr;
      cfg_idx = tbl[i].idx;
      cfg_wdata = tbl[i].wd;
      if (tbl[i].wr && int'(tbl[i].idx) < NP) shm[tbl[i].idx] = tbl[i].wd;
      @(negedge mclk);
      cfg_wr = 1'b0;
      check($sformatf("tbl%0d_rdata", i), 32'(cfg_rdata), 32'(tbl[i].exp));
    end

    stuck = 1'b0;
    run_seq(1'b1, -1, -1, 1'b0, 3'd0, 12'h0, 580, "t2");
    check("t2_pad5", 32'(pad_reg[5]), 32'h0ABC);
    check("t2_pad0", 32'(pad_reg[0]), 32'h0001);
    check("t2_err", 32'(loopback_err), 0);

    stuck = 1'b1;
    run_seq(1'b1, -1, -1, 1'b0, 3'd0, 12'h0, 580, "t3");
    check("t3_err", 32'(loopback_err), 1);
    stuck = 1'b0;

    run_seq(1'b0, 50, -1, 1'b0, 3'd0, 12'h0, 292, "t4");
    cfg_idx = 3'd2;
    #1;
    check("t4_pad2", 32'(cfg_rdata), 32'h0C00);

    run_seq(1'b0, -1, -1, 1'b1, 3'd2, 12'h555, 292, "t5");
    cfg_idx = 3'd2;
    #1;
    check("t5_pad2", 32'(cfg_rdata), 32'h0555);

    run_seq(1'b0, -1, 121, 1'b0, 3'd0, 12'h0, 0, "t6");
    cfg_idx = 3'd2;
    #1;
    check("t6_pad2", 32'(cfg_rdata), 32'h0C00);
    cfg_idx = 3'd5;
    #1;
    check("t6_pad5", 32'(cfg_rdata), 32'h0C00);

    run_seq(1'b0, -1, -1, 1'b0, 3'd0, 12'h0, 292, "t7");

    check("clk_load_ovl", ovl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
